// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects five raw push
// buttons, producing registered single-cycle pulses plus debounced levels.
// Up and down additionally auto-repeat while held and repeat_en is high.
// Bit order everywhere: 0 up, 1 down, 2 left, 3 right, 4 center.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES     = 1_000_000,
   parameter int REPEAT_DELAY_CYCLES = 50_000_000,
   parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] btn_raw,
   input  logic       repeat_en,
   output logic       btn_up,
   output logic       btn_down,
   output logic       btn_left,
   output logic       btn_right,
   output logic       btn_center,
   output logic [4:0] btn_level
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                         REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [RW-1:0] RR_LAST  = RW'(REPEAT_RATE_CYCLES - 1);

   // Handshake note: there is no valid/ready flow here; every output is a
   // level or a one-cycle pulse and the consumer must sample every cycle.

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_t;

   logic [4:0]    sync_meta;
   logic [4:0]    sync;
   logic [4:0]    stable;
   logic [4:0]    stable_q;
   logic [4:0]    press_evt;
   logic [DW-1:0] db_cnt [5];

   // Index 0 is the up channel, index 1 the down channel.
   rep_state_t    rep_state [2];
   logic [RW-1:0] rep_cnt   [2];
   logic [1:0]    rep_fire;
   logic [1:0]    rep_out;

   // Two-flop synchroniser for the asynchronous raw buttons.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= btn_raw;
         sync      <= sync_meta;
      end
   end

   // Debounce: the stable level flips only after DEBOUNCE_CYCLES consecutive
   // cycles of disagreement; any single cycle of agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable <= '0;
         for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (sync[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   // Delayed copy of the stable levels for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stable_q <= '0;
      else        stable_q <= stable;
   end

   assign press_evt = stable & ~stable_q;
   assign btn_level = stable;

   // Left, right and center carry press pulses only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_left   <= 1'b0;
         btn_right  <= 1'b0;
         btn_center <= 1'b0;
      end else begin
         btn_left   <= press_evt[2];
         btn_right  <= press_evt[3];
         btn_center <= press_evt[4];
      end
   end

   // A repeat fires on counter expiry only while still held and enabled, so an
   // abort on the same edge suppresses the pulse.
   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < 2; i++) begin
         rep_fire[i] = stable[i] && repeat_en &&
                       (((rep_state[i] == ST_DELAY)  && (rep_cnt[i] == RD_LAST)) ||
                        ((rep_state[i] == ST_REPEAT) && (rep_cnt[i] == RR_LAST)));
      end
   end

   // Hold-to-repeat FSMs for up/down with their registered pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            rep_state[i] <= ST_IDLE;
            rep_cnt[i]   <= '0;
         end
         rep_out <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            rep_out[i] <= press_evt[i] | rep_fire[i];
            case (rep_state[i])
               ST_IDLE: begin
                  rep_cnt[i] <= '0;
                  if (press_evt[i] && repeat_en) rep_state[i] <= ST_DELAY;
               end
               ST_DELAY: begin
                  if (!stable[i] || !repeat_en) begin
                     rep_state[i] <= ST_IDLE;
                     rep_cnt[i]   <= '0;
                  end else if (rep_cnt[i] == RD_LAST) begin
                     rep_state[i] <= ST_REPEAT;
                     rep_cnt[i]   <= '0;
                  end else begin
                     rep_cnt[i] <= rep_cnt[i] + RW'(1);
                  end
               end
               ST_REPEAT: begin
                  if (!stable[i] || !repeat_en) begin
                     rep_state[i] <= ST_IDLE;
                     rep_cnt[i]   <= '0;
                  end else if (rep_cnt[i] == RR_LAST) begin
                     rep_cnt[i] <= '0;
                  end else begin
                     rep_cnt[i] <= rep_cnt[i] + RW'(1);
                  end
               end
               default: begin
                  rep_state[i] <= ST_IDLE;
                  rep_cnt[i]   <= '0;
               end
            endcase
         end
      end
   end

   assign btn_up   = rep_out[0];
   assign btn_down = rep_out[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios followed by randomized
// bouncing stimulus, every cycle compared against a rule-based reference model.
module tb_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] btn_raw;
   logic       repeat_en;
   logic       btn_up, btn_down, btn_left, btn_right, btn_center;
   logic [4:0] btn_level;

   always #5 clk = ~clk;

   button_conditioner #(
      .DEBOUNCE_CYCLES     (D),
      .REPEAT_DELAY_CYCLES (RD),
      .REPEAT_RATE_CYCLES  (RR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .repeat_en  (repeat_en),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_center (btn_center),
      .btn_level  (btn_level)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   // raw_q holds the raw value seen before each of the last D+2 edges.
   logic [4:0] raw_q [$];
   logic [4:0] m_lvl;        // debounced level after the latest edge
   logic [4:0] m_lvl_p;      // debounced level one edge earlier
   logic [1:0] m_armed;      // up/down currently in a hold-to-repeat window
   int         m_press_edge [2];
   int         edge_n;
   logic [4:0] exp_pulse;

   // pulse statistics for directed latency checks
   int pulse_cnt  [5];
   int pulse_edge [5];
   int first_edge [5];
   int fall_edge  [5];
   logic [4:0] obs_lvl_prev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      raw_q.delete();
      for (int i = 0; i < D + 2; i++) raw_q.push_back(5'b0);
      m_lvl   = '0;
      m_lvl_p = '0;
      m_armed = '0;
      edge_n  = 0;
      obs_lvl_prev = '0;
   endtask

   task automatic clear_stats();
      for (int b = 0; b < 5; b++) begin
         pulse_cnt[b]  = 0;
         pulse_edge[b] = -1;
         first_edge[b] = -1;
         fall_edge[b]  = -1;
      end
   endtask

   // Rules: the level takes a new value once the raw input has shown it for D
   // consecutive samples, two cycles of synchroniser delay later. A press pulse
   // follows the level rise by one edge. Repeats land at press+RD+m*RR while the
   // level stays up and repeat_en stays high, and only if enabled at the press.
   task automatic model_edge(input logic [4:0] raw, input logic ren);
      logic [4:0] new_lvl;
      logic [1:0] rep;
      logic       all_diff;
      int         d;
      edge_n++;
      raw_q.push_back(raw);
      void'(raw_q.pop_front());
      new_lvl = m_lvl;
      for (int b = 0; b < 5; b++) begin
         all_diff = 1'b1;
         for (int j = 0; j < D; j++) if (raw_q[j][b] == m_lvl[b]) all_diff = 1'b0;
         if (all_diff) new_lvl[b] = ~m_lvl[b];
      end
      exp_pulse = m_lvl & ~m_lvl_p;
      rep = '0;
      for (int i = 0; i < 2; i++) begin
         if (m_armed[i]) begin
            if (!ren || !m_lvl[i]) begin
               m_armed[i] = 1'b0;
            end else begin
               d = edge_n - m_press_edge[i];
               if (d >= RD && ((d - RD) % RR) == 0) rep[i] = 1'b1;
            end
         end
         if (exp_pulse[i] && ren) begin
            m_armed[i]      = 1'b1;
            m_press_edge[i] = edge_n;
         end
      end
      exp_pulse[1:0] = exp_pulse[1:0] | rep;
      m_lvl_p = m_lvl;
      m_lvl   = new_lvl;
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [4:0] raw, input logic ren);
      logic [4:0] obs;
      btn_raw   = raw;
      repeat_en = ren;
      @(posedge clk);
      #1;
      model_edge(raw, ren);
      obs = {btn_center, btn_right, btn_left, btn_down, btn_up};
      check("pulses", {27'b0, obs}, {27'b0, exp_pulse});
      check("level", {27'b0, btn_level}, {27'b0, m_lvl});
      for (int b = 0; b < 5; b++) begin
         if (obs[b]) begin
            pulse_cnt[b]++;
            pulse_edge[b] = edge_n;
            if (first_edge[b] < 0) first_edge[b] = edge_n;
         end
         if (obs_lvl_prev[b] && !btn_level[b]) fall_edge[b] = edge_n;
      end
      obs_lvl_prev = btn_level;
   endtask

   task automatic hold(input logic [4:0] raw, input logic ren, input int n);
      for (int i = 0; i < n; i++) step(raw, ren);
   endtask

   // Asserts reset between edges, checks the asynchronous clear, then releases.
   task automatic apply_reset(input logic [4:0] raw);
      btn_raw = raw;
      rst_n   = 1'b0;
      #1;
      check("reset_pulses_async",
            {27'b0, btn_center, btn_right, btn_left, btn_down, btn_up}, 32'd0);
      check("reset_level_async", {27'b0, btn_level}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_pulses_held",
            {27'b0, btn_center, btn_right, btn_left, btn_down, btn_up}, 32'd0);
      rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- stimulus ----------------
   int t0;
   int hold_left [5];
   logic [4:0] rnd_raw;
   logic rnd_ren;

   initial begin
      rst_n     = 1'b0;
      btn_raw   = '0;
      repeat_en = 1'b0;
      #2;
      check("por_pulses",
            {27'b0, btn_center, btn_right, btn_left, btn_down, btn_up}, 32'd0);
      check("por_level", {27'b0, btn_level}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      clear_stats();
      hold(5'b0, 1'b1, 5);

      // Clean press of left, held 20 cycles, then release.
      clear_stats();
      t0 = edge_n;
      hold(5'b00100, 1'b1, 20);
      check("s1_left_latency", pulse_edge[2], t0 + 7);
      check("s1_left_count", pulse_cnt[2], 1);
      t0 = edge_n;
      hold(5'b0, 1'b1, 10);
      check("s1_level_fall", fall_edge[2], t0 + 6);

      // Bounce on left, then steady press.
      clear_stats();
      step(5'b00100, 1'b1);
      step(5'b00000, 1'b1);
      step(5'b00100, 1'b1);
      step(5'b00100, 1'b1);
      step(5'b00000, 1'b1);
      t0 = edge_n;
      hold(5'b00100, 1'b1, 15);
      check("s2_bounce_latency", pulse_edge[2], t0 + 7);
      check("s2_bounce_count", pulse_cnt[2], 1);
      hold(5'b0, 1'b1, 10);

      // Hold up with repeat enabled for 30 cycles after the press pulse.
      clear_stats();
      t0 = edge_n;
      hold(5'b00001, 1'b1, 37);
      check("s3_press_edge", first_edge[0], t0 + 7);
      check("s3_repeat_count", pulse_cnt[0], 8);
      check("s3_last_repeat", pulse_edge[0], t0 + 7 + 28);
      hold(5'b0, 1'b1, 12);

      // Same hold with repeat disabled: press pulse only.
      clear_stats();
      hold(5'b00001, 1'b0, 37);
      check("s3_norepeat_count", pulse_cnt[0], 1);
      hold(5'b0, 1'b0, 10);

      // All five buttons together; up and down repeat in lockstep.
      clear_stats();
      t0 = edge_n;
      hold(5'b11111, 1'b1, 20);
      for (int b = 0; b < 5; b++) check("s4_same_cycle", first_edge[b], t0 + 7);
      check("s4_up_count", pulse_cnt[0], 3);
      check("s4_down_count", pulse_cnt[1], 3);
      check("s4_center_count", pulse_cnt[4], 1);
      hold(5'b0, 1'b1, 10);

      // Reset while up is in its repeat phase, button still held afterwards.
      hold(5'b00001, 1'b1, 20);
      apply_reset(5'b00001);
      clear_stats();
      hold(5'b00001, 1'b1, 25);
      check("s5_press_after_reset", first_edge[0], 7);
      check("s5_repeat_count", pulse_cnt[0], 4);
      hold(5'b0, 1'b1, 10);

      // Drop repeat_en exactly on the DELAY expiry edge, then re-raise it.
      clear_stats();
      for (int s = 1; s <= 30; s++) step(5'b00001, (s == 17) ? 1'b0 : 1'b1);
      check("s6_abort_count", pulse_cnt[0], 1);
      hold(5'b0, 1'b1, 10);
      clear_stats();
      hold(5'b00001, 1'b1, 20);
      check("s6_new_press_count", pulse_cnt[0], 3);
      hold(5'b0, 1'b1, 10);

      // Randomized bouncing buttons and occasional repeat_en toggles.
      rnd_raw = '0;
      rnd_ren = 1'b1;
      for (int b = 0; b < 5; b++) hold_left[b] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 5; b++) begin
            if (hold_left[b] == 0) begin
               rnd_raw[b] = ~rnd_raw[b];
               if ($urandom_range(0, 9) < 4) hold_left[b] = $urandom_range(1, 3);
               else                          hold_left[b] = $urandom_range(5, 40);
            end
            hold_left[b]--;
         end
         if ($urandom_range(0, 63) == 0) rnd_ren = ~rnd_ren;
         if (c == 1500) apply_reset(rnd_raw);
         step(rnd_raw, rnd_ren);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
